turbo_len_burst: RTL and testbench

- Parametrised successor of the turbo length/enable generator in the HPGP turbo interleaver RX path.
- Maps a PB size code, or a programmed length, to interleaver length L in bit-pairs.
- Generates the per-sample address `enable`, write strobe `wen` and running `pb_offset` across a burst of 1..2^NPB_W-1 PBs.
- Adds a start/busy/done handshake, abort, a config error flag and a per-PB done pulse.

---
 rtl/turbo_len_burst.sv | 138 +++++++++++++
 tb/tb_turbo_len_burst.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/turbo_len_burst.sv
// turbo_len_burst: interleaver length/enable generator for a burst of 1..2^NPB_W-1 PBs
// Ports:
//   clk, n_rst          clock (rising edge), asynchronous active-low reset
//   start, abort        burst request (IDLE only), dominant synchronous abort
//   pb_size, len_cfg    PB size code (3 selects len_cfg), programmed length
//   num_pb              PBs in the burst (0 illegal)
//   din_vld             one input bit-pair this cycle
//   enable, pb_offset   address within PB, pb_idx*L
//   pb_idx, wen         current PB index, enable/pb_offset valid strobe
//   pb_done, done       last sample of PB / of burst
//   busy, cfg_err       LOAD or RUN, sticky illegal-config flag
module turbo_len_burst #(
  parameter int CNT_W = 12,
  parameter int NPB_W = 4,
  parameter int OFS_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       pb_size,
  input  logic [CNT_W-1:0] len_cfg,
  input  logic [NPB_W-1:0] num_pb,
  input  logic             din_vld,
  output logic [CNT_W-1:0] enable,
  output logic [OFS_W-1:0] pb_offset,
  output logic [NPB_W-1:0] pb_idx,
  output logic             wen,
  output logic             pb_done,
  output logic             done,
  output logic             busy,
  output logic             cfg_err
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d, enable_q, enable_d;
  logic [NPB_W-1:0] npb_q, npb_d, idx_q, idx_d, pb_idx_q, pb_idx_d;
  logic [OFS_W-1:0] acc_q, acc_d, ofs_q, ofs_d;
  logic             wen_q, wen_d, pbd_q, pbd_d, done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0] len_sel;
  logic             last_smp, last_pb;
  assign len_sel  = pb_size == 2'd3 ? len_cfg :
                    pb_size == 2'd2 ? CNT_W'(2080) :
                    pb_size == 2'd1 ? CNT_W'(544) : CNT_W'(64);
  assign last_smp = cnt_q == len_q - CNT_W'(1);
  assign last_pb  = idx_q == npb_q - NPB_W'(1);
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    npb_d    = npb_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    enable_d = enable_q;
    ofs_d    = ofs_q;
    pb_idx_d = pb_idx_q;
    err_d    = err_q;
    wen_d    = 1'b0;
    pbd_d    = 1'b0;
    done_d   = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = start ? LOAD : IDLE;
        LOAD: begin
          len_d = len_sel;
          npb_d = num_pb;
          if (len_sel == '0 || num_pb == '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            acc_d   = '0;
            state_d = RUN;
          end
        end
        RUN: if (din_vld) begin
          wen_d    = 1'b1;
          enable_d = cnt_q;
          ofs_d    = acc_q;
          pb_idx_d = idx_q;
          pbd_d    = last_smp;
          done_d   = last_smp && last_pb;
          cnt_d    = last_smp ? '0 : cnt_q + CNT_W'(1);
          acc_d    = last_smp ? acc_q + OFS_W'(len_q) : acc_q;
          idx_d    = last_smp ? idx_q + NPB_W'(1) : idx_q;
          state_d  = last_smp && last_pb ? IDLE : RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      npb_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      enable_q <= '0;
      ofs_q    <= '0;
      pb_idx_q <= '0;
      wen_q    <= 1'b0;
      pbd_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      npb_q    <= npb_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      enable_q <= enable_d;
      ofs_q    <= ofs_d;
      pb_idx_q <= pb_idx_d;
      wen_q    <= wen_d;
      pbd_q    <= pbd_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign enable    = enable_q;
  assign pb_offset = ofs_q;
  assign pb_idx    = pb_idx_q;
  assign wen       = wen_q;
  assign pb_done   = pbd_q;
  assign done      = done_q;
  assign busy      = state_q != IDLE;
  assign cfg_err   = err_q;
endmodule

// File: tb/tb_turbo_len_burst.sv
// tb_turbo_len_burst: randomized bench against a per-burst sample-list model
module tb_turbo_len_burst;
  localparam int CW = 12;
  localparam int NW = 4;
  localparam int OW = 16;
  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          din_vld = 1'b0;
  logic [1:0]    pb_size = '0;
  logic [CW-1:0] len_cfg = '0;
  logic [NW-1:0] num_pb = '0;
  logic [CW-1:0] enable;
  logic [OW-1:0] pb_offset;
  logic [NW-1:0] pb_idx;
  logic          wen, pb_done, done, busy, cfg_err;
  always #5 clk = ~clk;
  turbo_len_burst #(.CNT_W(CW), .NPB_W(NW), .OFS_W(OW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .pb_size(pb_size),
    .len_cfg(len_cfg), .num_pb(num_pb), .din_vld(din_vld), .enable(enable),
    .pb_offset(pb_offset), .pb_idx(pb_idx), .wen(wen), .pb_done(pb_done),
    .done(done), .busy(busy), .cfg_err(cfg_err)
  );
  typedef struct {int en; int ofs; int idx; bit pd; bit dn;} smp_t;
  smp_t q[$];
  int   phase = 0;
  int   m_en = 0, m_ofs = 0, m_idx = 0;
  bit   m_wen = 0, m_pd = 0, m_dn = 0, m_err = 0;
  bit   tog = 0;
  int   checks = 0, errors = 0;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int len_of(input logic [1:0] ps, input logic [CW-1:0] lc);
    return ps == 2'd0 ? 64 : ps == 2'd1 ? 544 : ps == 2'd2 ? 2080 : int'(lc);
  endfunction
  task automatic model();
    m_wen = 0;
    m_pd  = 0;
    m_dn  = 0;
    if (abort) begin
      phase = 0;
      q.delete();
    end else if (phase == 0) begin
      if (start) phase = 1;
    end else if (phase == 1) begin
      int l;
      int n;
      l = len_of(pb_size, len_cfg);
      n = int'(num_pb);
      if (l == 0 || n == 0) begin
        m_err = 1;
        phase = 0;
      end else begin
        m_err = 0;
        for (int p = 0; p < n; p++)
          for (int e = 0; e < l; e++)
            q.push_back('{e, p * l, p, e == l - 1, (e == l - 1) && (p == n - 1)});
        phase = 2;
      end
    end else if (din_vld && q.size() > 0) begin
      smp_t s;
      s = q.pop_front();
      m_wen = 1;
      m_en  = s.en;
      m_ofs = s.ofs;
      m_idx = s.idx;
      m_pd  = s.pd;
      m_dn  = s.dn;
      if (s.dn) phase = 0;
    end
  endtask
  task automatic compare();
    check("wen", int'(wen), int'(m_wen));
    check("pb_done", int'(pb_done), int'(m_pd));
    check("done", int'(done), int'(m_dn));
    check("busy", int'(busy), int'(phase != 0));
    check("cfg_err", int'(cfg_err), int'(m_err));
    if (m_wen || phase != 0) begin
      check("enable", int'(enable), m_en);
      check("pb_offset", int'(pb_offset), m_ofs);
      check("pb_idx", int'(pb_idx), m_idx);
    end
  endtask
  task automatic step(input bit st, input bit ab, input bit dv);
    @(negedge clk);
    start   = st;
    abort   = ab;
    din_vld = dv;
    model();
    @(posedge clk);
    #1;
    compare();
  endtask
  task automatic run_burst(input int mode, input int max);
    for (int i = 0; i < max && phase != 0; i++) begin
      tog = ~tog;
      if (mode == 0) step(0, 0, 1);
      else if (mode == 1) step(0, 0, tog);
      else step($urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1);
    end
    check("burst_end_busy", int'(busy), 0);
  endtask
  task automatic async_reset();
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_enable", int'(enable), 0);
    check("rst_pb_offset", int'(pb_offset), 0);
    check("rst_pb_idx", int'(pb_idx), 0);
    check("rst_wen", int'(wen), 0);
    check("rst_pb_done", int'(pb_done), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    phase = 0;
    q.delete();
    m_en = 0; m_ofs = 0; m_idx = 0;
    m_wen = 0; m_pd = 0; m_dn = 0; m_err = 0;
    @(negedge clk);
    start = 0; abort = 0; din_vld = 0;
    n_rst = 1'b1;
  endtask
  initial begin
    #12;
    check("init_enable", int'(enable), 0);
    check("init_pb_offset", int'(pb_offset), 0);
    check("init_wen", int'(wen), 0);
    check("init_busy", int'(busy), 0);
    check("init_cfg_err", int'(cfg_err), 0);
    @(negedge clk);
    n_rst = 1'b1;
    pb_size = 2'd1; num_pb = 4'd1;
    step(1, 0, 0);
    for (int i = 0; i < 700 && !(m_wen && m_en == 100); i++) step(0, 0, 1);
    check("pre_reset_enable", int'(enable), 100);
    async_reset();
    pb_size = 2'd0; num_pb = 4'd1;
    step(1, 0, 0);
    run_burst(0, 200);
    pb_size = 2'd2; num_pb = 4'd3;
    step(1, 0, 0);
    run_burst(1, 13000);
    pb_size = 2'd3; len_cfg = 12'd0; num_pb = 4'd1;
    step(1, 0, 1);
    run_burst(0, 10);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    len_cfg = 12'd5; num_pb = 4'd0;
    step(1, 0, 1);
    run_burst(0, 10);
    step(0, 0, 1);
    num_pb = 4'd2;
    step(1, 0, 0);
    run_burst(0, 40);
    step(1, 1, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    pb_size = 2'd1; num_pb = 4'd2;
    step(1, 0, 0);
    for (int i = 0; i < 2000 && !(m_wen && m_idx == 1 && m_en == 300); i++) step(0, 0, 1);
    check("pre_abort_enable", int'(enable), 300);
    step(0, 1, 1);
    step(1, 0, 1);
    run_burst(0, 1200);
    pb_size = 2'd3; len_cfg = 12'd1; num_pb = 4'd4;
    step(1, 0, 1);
    run_burst(0, 20);
    step(1, 0, 1);
    run_burst(0, 20);
    for (int k = 0; k < 24; k++) begin
      pb_size = 2'($urandom_range(0, 3));
      len_cfg = CW'($urandom_range(0, 40));
      num_pb  = NW'(pb_size == 2'd2 ? $urandom_range(0, 1) : $urandom_range(0, 3));
      step(1, 0, $urandom_range(0, 1) == 1);
      run_burst(2, 6000);
      step(0, 0, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
